// File: rtl/decode_issue_pkg.sv
// Shared constants and types for the decode/issue stage: execute command
// encodings, instruction field positions, register-file geometry and the
// issue-slot record handed to execute.
package decode_issue_pkg;

    // Register file geometry and datapath width (must match execute).
    localparam int NREG   = 4;
    localparam int REG_AW = 2;
    localparam int DW     = 8;

    // Instruction word layout: [15]=IMM, [14:12]=op, [11:10]=rd, [9:8]=rs, [7:0]=imm8.
    localparam int INST_W        = 16;
    localparam int INST_IMM_BIT  = 15;
    localparam int INST_OP_MSB   = 14;
    localparam int INST_OP_LSB   = 12;
    localparam int INST_RD_MSB   = 11;
    localparam int INST_RD_LSB   = 10;
    localparam int INST_RS_MSB   = 9;
    localparam int INST_RS_LSB   = 8;
    localparam int INST_IMM8_MSB = 7;
    localparam int INST_IMM8_LSB = 0;

    // Execute command encodings. The low eight codes are the ALU ops straight
    // from the instruction; execute owns their meaning. NOP marks a bubble.
    typedef enum logic [3:0] {
        EXE_OP0 = 4'h0,
        EXE_OP1 = 4'h1,
        EXE_OP2 = 4'h2,
        EXE_OP3 = 4'h3,
        EXE_OP4 = 4'h4,
        EXE_OP5 = 4'h5,
        EXE_OP6 = 4'h6,
        EXE_OP7 = 4'h7,
        EXE_NOP = 4'hF
    } exe_cmd_e;

    // Decoded instruction fields.
    typedef struct packed {
        logic              imm;
        logic [2:0]        op;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs;
        logic [DW-1:0]     imm8;
    } inst_t;

    // Contents of the issue slot presented to execute.
    typedef struct packed {
        exe_cmd_e          cmd;
        logic [DW-1:0]     src0;
        logic [DW-1:0]     src1;
        logic [REG_AW-1:0] dest;
        logic              valid;
    } issue_t;

    // An empty slot: used both at reset and whenever nothing is issued.
    localparam issue_t ISSUE_BUBBLE = '{
        cmd:   EXE_NOP,
        src0:  '0,
        src1:  '0,
        dest:  '0,
        valid: 1'b0
    };

    // Interlock sequencing: INTERLOCK marks the cycle after a hazard bubble.
    typedef enum logic {
        ST_ISSUE     = 1'b0,
        ST_INTERLOCK = 1'b1
    } state_e;

    // Split a raw instruction word into its fields.
    function automatic inst_t decode_fields(input logic [INST_W-1:0] word);
        inst_t f;
        f.imm  = word[INST_IMM_BIT];
        f.op   = word[INST_OP_MSB:INST_OP_LSB];
        f.rd   = word[INST_RD_MSB:INST_RD_LSB];
        f.rs   = word[INST_RS_MSB:INST_RS_LSB];
        f.imm8 = word[INST_IMM8_MSB:INST_IMM8_LSB];
        return f;
    endfunction

    // The command sent to execute is the ALU op with a zero top bit.
    function automatic exe_cmd_e op_to_cmd(input logic [2:0] op);
        return exe_cmd_e'({1'b0, op});
    endfunction

endpackage

// File: rtl/decode_regfile.sv
// 4x8 architectural register file owned by the decode stage. One write port
// fed by writeback, three combinational read ports. A read of the address
// being written in the same cycle returns the incoming data (write-through).
module decode_regfile
    import decode_issue_pkg::*;
(
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              wb_we_i,
    input  logic [REG_AW-1:0] wb_addr_i,
    input  logic [DW-1:0]     wb_data_i,
    input  logic [REG_AW-1:0] rd_addr_i,
    output logic [DW-1:0]     rd_data_o,
    input  logic [REG_AW-1:0] rs_addr_i,
    output logic [DW-1:0]     rs_data_o,
    input  logic [REG_AW-1:0] spare_addr_i,
    output logic [DW-1:0]     spare_data_o
);

    logic [DW-1:0] regs_q [NREG];

    // Register array: cleared on reset, written by writeback on the clock edge.
    // NOTE: this array is small and architecturally visible, so it is reset like
    // any other state; large RAM-style memories normally are not.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_we_i) begin
            regs_q[wb_addr_i] <= wb_data_i;
        end
    end

    // Read ports with write-through bypass of the word being written this cycle.
    always_comb begin
        rd_data_o    = (wb_we_i && (wb_addr_i == rd_addr_i))    ? wb_data_i : regs_q[rd_addr_i];
        rs_data_o    = (wb_we_i && (wb_addr_i == rs_addr_i))    ? wb_data_i : regs_q[rs_addr_i];
        spare_data_o = (wb_we_i && (wb_addr_i == spare_addr_i)) ? wb_data_i : regs_q[spare_addr_i];
    end

endmodule

// File: rtl/decode_issue.sv
// Decode/issue stage feeding execute. Accepts instruction words from fetch,
// reads operands from the local register file, forwards execute's registered
// result, and interlocks for one cycle when the next instruction depends on
// the one currently sitting in the issue slot.
module decode_issue
    import decode_issue_pkg::*;
(
    input  logic              iCLK,
    input  logic              iRST,
    input  logic [INST_W-1:0] iINST,
    input  logic              iINST_VALID,
    output logic              oINST_READY,
    input  logic              iEXE_STALL,
    output logic [3:0]        oEXE_CMD,
    output logic [DW-1:0]     oSOURCE0,
    output logic [DW-1:0]     oSOURCE1,
    output logic [REG_AW-1:0] oDEST,
    output logic              oEXE_VALID,
    input  logic              iEX_VALID,
    input  logic [REG_AW-1:0] iEX_DEST,
    input  logic [DW-1:0]     iEX_RESULT,
    input  logic              iWB_WE,
    input  logic [REG_AW-1:0] iWB_ADDR,
    input  logic [DW-1:0]     iWB_DATA
);

    inst_t         inst;
    issue_t        issue_q, issue_d;
    state_e        state_q, state_d;
    logic [DW-1:0] rf_rd_data;
    logic [DW-1:0] rf_rs_data;
    logic [DW-1:0] unused_spare_data;
    logic [DW-1:0] src0_val;
    logic [DW-1:0] rs_val;
    logic [DW-1:0] src1_val;
    logic          hazard;
    logic          accept;

    assign inst = decode_fields(iINST);

    // The spare port is wired to the slot's destination so it is available for
    // a future consumer; this stage itself does not read it.
    decode_regfile u_regfile (
        .iCLK         (iCLK),
        .iRST         (iRST),
        .wb_we_i      (iWB_WE),
        .wb_addr_i    (iWB_ADDR),
        .wb_data_i    (iWB_DATA),
        .rd_addr_i    (inst.rd),
        .rd_data_o    (rf_rd_data),
        .rs_addr_i    (inst.rs),
        .rs_data_o    (rf_rs_data),
        .spare_addr_i (issue_q.dest),
        .spare_data_o (unused_spare_data)
    );

    // Execute's registered result outranks the register file (which already
    // carries the same-cycle writeback bypass) because it is the newer value.
    function automatic logic [DW-1:0] forward(
        input logic [REG_AW-1:0] addr,
        input logic [DW-1:0]     rf_val,
        input logic              ex_valid,
        input logic [REG_AW-1:0] ex_dest,
        input logic [DW-1:0]     ex_result
    );
        return (ex_valid && (ex_dest == addr)) ? ex_result : rf_val;
    endfunction

    // Operand selection: forwarded register values, immediate replaces rs.
    always_comb begin
        src0_val = forward(inst.rd, rf_rd_data, iEX_VALID, iEX_DEST, iEX_RESULT);
        rs_val   = forward(inst.rs, rf_rs_data, iEX_VALID, iEX_DEST, iEX_RESULT);
        src1_val = inst.imm ? inst.imm8 : rs_val;
    end

    // The slot's result only reaches iEX_RESULT one cycle after issue, so an
    // instruction reading that destination must wait a cycle. rs is only a
    // dependency when the immediate is not used.
    assign hazard = (state_q == ST_ISSUE) && issue_q.valid &&
                    ((issue_q.dest == inst.rd) ||
                     (!inst.imm && (issue_q.dest == inst.rs)));

    assign oINST_READY = !iRST && !iEXE_STALL && !hazard;
    assign accept      = iINST_VALID && oINST_READY;

    // Next slot contents and interlock state; a stall holds everything.
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        issue_d = issue_q;
        state_d = state_q;
        if (!iEXE_STALL) begin
            if (accept) begin
                issue_d.cmd   = op_to_cmd(inst.op);
                issue_d.src0  = src0_val;
                issue_d.src1  = src1_val;
                issue_d.dest  = inst.rd;
                issue_d.valid = 1'b1;
                state_d       = ST_ISSUE;
            end else begin
                issue_d = ISSUE_BUBBLE;
                state_d = (iINST_VALID && hazard) ? ST_INTERLOCK : ST_ISSUE;
            end
        end
    end

    // Issue slot and interlock state registers; reset empties the slot and
    // drops any pending interlock.
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of block evaluation order.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            issue_q <= ISSUE_BUBBLE;
            state_q <= ST_ISSUE;
        end else begin
            issue_q <= issue_d;
            state_q <= state_d;
        end
    end

    assign oEXE_CMD   = issue_q.cmd;
    assign oSOURCE0   = issue_q.src0;
    assign oSOURCE1   = issue_q.src1;
    assign oDEST      = issue_q.dest;
    assign oEXE_VALID = issue_q.valid;

endmodule

// File: tb/tb_decode_issue.sv
// Bench for decode_issue. Directed cases first (execute/writeback driven by
// hand), then a reset in mid-stream, then randomized traffic with a small
// execute model closing the loop. Expected issue slots come from an
// in-order architectural model and are queued; a monitor compares them.
module tb_decode_issue;

    typedef struct packed {
        logic [3:0] cmd;
        logic [7:0] s0;
        logic [7:0] s1;
        logic [1:0] dest;
    } exp_t;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic [15:0] iINST;
    logic        iINST_VALID;
    logic        oINST_READY;
    logic        iEXE_STALL;
    logic [3:0]  oEXE_CMD;
    logic [7:0]  oSOURCE0;
    logic [7:0]  oSOURCE1;
    logic [1:0]  oDEST;
    logic        oEXE_VALID;
    logic        iEX_VALID;
    logic [1:0]  iEX_DEST;
    logic [7:0]  iEX_RESULT;
    logic        iWB_WE;
    logic [1:0]  iWB_ADDR;
    logic [7:0]  iWB_DATA;

    // Hand-driven execute/writeback values for the directed cases.
    logic       d_ex_valid, d_wb_we;
    logic [1:0] d_ex_dest, d_wb_addr;
    logic [7:0] d_ex_result, d_wb_data;
    // Execute model for the random phase.
    logic       ex_en;
    logic       ex_m_valid;
    logic [1:0] ex_m_dest;
    logic [7:0] ex_m_result;

    logic       rnd_mode;
    logic [7:0] arch [4];
    exp_t       sb_q [$];
    int         tests_run    = 0;
    int         tests_failed = 0;
    logic       mon_loaded;
    exp_t       mon_e;

    assign iEX_VALID  = ex_en ? ex_m_valid  : d_ex_valid;
    assign iEX_DEST   = ex_en ? ex_m_dest   : d_ex_dest;
    assign iEX_RESULT = ex_en ? ex_m_result : d_ex_result;
    assign iWB_WE     = ex_en ? ex_m_valid  : d_wb_we;
    assign iWB_ADDR   = ex_en ? ex_m_dest   : d_wb_addr;
    assign iWB_DATA   = ex_en ? ex_m_result : d_wb_data;

    decode_issue dut (
        .iCLK        (iCLK),
        .iRST        (iRST),
        .iINST       (iINST),
        .iINST_VALID (iINST_VALID),
        .oINST_READY (oINST_READY),
        .iEXE_STALL  (iEXE_STALL),
        .oEXE_CMD    (oEXE_CMD),
        .oSOURCE0    (oSOURCE0),
        .oSOURCE1    (oSOURCE1),
        .oDEST       (oDEST),
        .oEXE_VALID  (oEXE_VALID),
        .iEX_VALID   (iEX_VALID),
        .iEX_DEST    (iEX_DEST),
        .iEX_RESULT  (iEX_RESULT),
        .iWB_WE      (iWB_WE),
        .iWB_ADDR    (iWB_ADDR),
        .iWB_DATA    (iWB_DATA)
    );

    always #5 iCLK = ~iCLK;

    // Arbitrary ALU used by both the execute model and the architectural model.
    function automatic logic [7:0] alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return b;
            3'd6:    return {a[6:0], 1'b0};
            default: return ~b;
        endcase
    endfunction

    // Execute model: registers the issued slot's result, which is also the writeback.
    always @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            ex_m_valid  <= 1'b0;
            ex_m_dest   <= 2'd0;
            ex_m_result <= 8'd0;
        end else if (!iEXE_STALL) begin
            ex_m_valid  <= oEXE_VALID;
            ex_m_dest   <= oDEST;
            ex_m_result <= alu(oEXE_CMD[2:0], oSOURCE0, oSOURCE1);
        end else begin
            ex_m_valid  <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: a slot loaded at an unstalled edge with valid set is one issue.
    initial begin
        forever begin
            @(posedge iCLK);
            mon_loaded = !iEXE_STALL && !iRST;
            @(negedge iCLK);
            if (mon_loaded && oEXE_VALID) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_issue", {31'd0, oEXE_VALID}, 32'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("issue", {10'd0, oEXE_CMD, oSOURCE0, oSOURCE1, oDEST}, {10'd0, mon_e});
                end
            end
        end
    end

    // Move to the drive point just after the next rising edge.
    task automatic tick();
        @(posedge iCLK);
        #1;
        if (rnd_mode) iEXE_STALL = ($urandom_range(0, 4) == 0);
    endtask

    // In-order architectural reference: operands are register values as of
    // program order, then the destination takes the ALU result.
    task automatic push_model(input logic [15:0] inst);
        exp_t       e;
        logic       imm;
        logic [2:0] op;
        logic [1:0] rd, rs;
        imm    = inst[15];
        op     = inst[14:12];
        rd     = inst[11:10];
        rs     = inst[9:8];
        e.cmd  = {1'b0, op};
        e.s0   = arch[rd];
        e.s1   = imm ? inst[7:0] : arch[rs];
        e.dest = rd;
        sb_q.push_back(e);
        arch[rd] = alu(op, e.s0, e.s1);
    endtask

    // Present one instruction until accepted; waits = cycles spent not ready.
    task automatic send(input logic [15:0] inst, input bit use_given, input exp_t given, output int waits);
        waits       = 0;
        iINST       = inst;
        iINST_VALID = 1'b1;
        forever begin
            @(negedge iCLK);
            if (oINST_READY) begin
                if (use_given) sb_q.push_back(given);
                else           push_model(inst);
                break;
            end
            waits++;
            if (waits > 40) begin
                check("accept_timeout", {31'd0, oINST_READY}, 32'd1);
                break;
            end
            tick();
        end
        tick();
        iINST_VALID = 1'b0;
    endtask

    task automatic idle(input int n);
        iINST_VALID = 1'b0;
        iINST       = 16'($urandom);
        repeat (n) tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int         w;
        logic [15:0] inst;
        iRST        = 1'b1;
        iINST       = 16'h0;
        iINST_VALID = 1'b0;
        iEXE_STALL  = 1'b0;
        d_ex_valid  = 1'b0; d_ex_dest = 2'd0; d_ex_result = 8'd0;
        d_wb_we     = 1'b0; d_wb_addr = 2'd0; d_wb_data   = 8'd0;
        ex_en       = 1'b0;
        rnd_mode    = 1'b0;
        for (int i = 0; i < 4; i++) arch[i] = 8'd0;

        // Reset state.
        #1;
        check("rst_cmd",   {28'd0, oEXE_CMD}, 32'hF);
        check("rst_src0",  {24'd0, oSOURCE0}, 32'd0);
        check("rst_src1",  {24'd0, oSOURCE1}, 32'd0);
        check("rst_dest",  {30'd0, oDEST},    32'd0);
        check("rst_valid", {31'd0, oEXE_VALID}, 32'd0);
        check("rst_ready", {31'd0, oINST_READY}, 32'd0);
        @(negedge iCLK);
        iRST = 1'b0;
        tick();

        // Immediate issue after writing R1=5.
        d_wb_we = 1'b1; d_wb_addr = 2'd1; d_wb_data = 8'd5;
        tick();
        d_wb_we = 1'b0;
        send({1'b1, 3'd0, 2'd1, 2'd0, 8'd7}, 1'b1, '{cmd: 4'd0, s0: 8'd5, s1: 8'd7, dest: 2'd1}, w);

        // RAW interlock: producer rd=2, consumer rs=2 gets the forwarded 42.
        // Writeback to R2 in the same cycle carries 99; execute's value must win.
        send({1'b1, 3'd1, 2'd2, 2'd0, 8'h10}, 1'b1, '{cmd: 4'd1, s0: 8'd0, s1: 8'h10, dest: 2'd2}, w);
        iINST       = {1'b0, 3'd2, 2'd0, 2'd2, 8'h00};
        iINST_VALID = 1'b1;
        @(negedge iCLK);
        check("raw_ready_low", {31'd0, oINST_READY}, 32'd0);
        tick();
        d_ex_valid = 1'b1; d_ex_dest = 2'd2; d_ex_result = 8'd42;
        d_wb_we    = 1'b1; d_wb_addr = 2'd2; d_wb_data   = 8'd99;
        @(negedge iCLK);
        check("raw_bubble_valid", {31'd0, oEXE_VALID}, 32'd0);
        check("raw_bubble_cmd",   {28'd0, oEXE_CMD},   32'hF);
        check("raw_ready_high",   {31'd0, oINST_READY}, 32'd1);
        if (oINST_READY) sb_q.push_back('{cmd: 4'd2, s0: 8'd0, s1: 8'd42, dest: 2'd0});
        tick();
        iINST_VALID = 1'b0;
        d_ex_valid  = 1'b0;
        d_wb_we     = 1'b0;
        tick();

        // Independent back-to-back pair: no wait cycles.
        send({1'b1, 3'd3, 2'd0, 2'd0, 8'h11}, 1'b1, '{cmd: 4'd3, s0: 8'd0, s1: 8'h11, dest: 2'd0}, w);
        check("indep_first_wait", w, 0);
        send({1'b0, 3'd4, 2'd3, 2'd1, 8'h5A}, 1'b1, '{cmd: 4'd4, s0: 8'd0, s1: 8'd5, dest: 2'd3}, w);
        check("indep_second_wait", w, 0);

        // Downstream stall for 3 cycles: slot frozen, nothing accepted.
        iEXE_STALL  = 1'b1;
        iINST       = {1'b1, 3'd5, 2'd1, 2'd2, 8'h22};
        iINST_VALID = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge iCLK);
            check("stall_ready", {31'd0, oINST_READY}, 32'd0);
            check("stall_frozen", {9'd0, oEXE_CMD, oSOURCE0, oSOURCE1, oDEST, oEXE_VALID},
                  {9'd0, 4'd4, 8'd0, 8'd5, 2'd3, 1'b1});
            tick();
        end
        iEXE_STALL = 1'b0;
        send({1'b1, 3'd5, 2'd1, 2'd2, 8'h22}, 1'b1, '{cmd: 4'd5, s0: 8'd5, s1: 8'h22, dest: 2'd1}, w);

        // Writeback bypass: R3 written with A5 in the cycle that reads rs=3.
        d_wb_we = 1'b1; d_wb_addr = 2'd3; d_wb_data = 8'hA5;
        send({1'b0, 3'd6, 2'd2, 2'd3, 8'h00}, 1'b1, '{cmd: 4'd6, s0: 8'd99, s1: 8'hA5, dest: 2'd2}, w);
        d_wb_we = 1'b0;
        check("wb_bypass_wait", w, 0);
        send({1'b0, 3'd7, 2'd3, 2'd3, 8'h00}, 1'b1, '{cmd: 4'd7, s0: 8'hA5, s1: 8'hA5, dest: 2'd3}, w);

        // Reset while the slot holds a live instruction.
        @(negedge iCLK);
        check("pre_reset_valid", {31'd0, oEXE_VALID}, 32'd1);
        #1;
        iRST = 1'b1;
        #1;
        check("mid_rst_cmd",   {28'd0, oEXE_CMD},   32'hF);
        check("mid_rst_src",   {16'd0, oSOURCE0, oSOURCE1}, 32'd0);
        check("mid_rst_dest",  {30'd0, oDEST},      32'd0);
        check("mid_rst_valid", {31'd0, oEXE_VALID}, 32'd0);
        check("mid_rst_ready", {31'd0, oINST_READY}, 32'd0);
        check("sb_drained_directed", sb_q.size(), 0);
        sb_q.delete();
        ex_en = 1'b1;
        for (int i = 0; i < 4; i++) arch[i] = 8'd0;
        @(negedge iCLK);
        @(negedge iCLK);
        iRST = 1'b0;
        tick();

        // Registers read back zero after reset.
        for (int r = 0; r < 4; r++) begin
            inst = {1'b0, 3'($urandom), 2'(r), 2'(r), 8'($urandom)};
            send(inst, 1'b0, '0, w);
        end

        // Randomized traffic with random stalls and gaps.
        rnd_mode = 1'b1;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            inst = 16'($urandom);
            send(inst, 1'b0, '0, w);
        end
        rnd_mode   = 1'b0;
        iEXE_STALL = 1'b0;
        idle(6);
        check("sb_drained", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
